// File: rtl/drp_responder.sv
// drp_responder: MMCM/PLL DRP responder model with a 128x16 register file,
// programmable DRDY latency, protocol-violation flags and LOCKED emulation.
module drp_responder #(
    parameter int DRDY_LATENCY = 3,
    parameter int LOCK_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  daddr,
    input  logic [15:0] din,
    input  logic        den,
    input  logic        dwe,
    output logic [15:0] dout,
    output logic        drdy,
    input  logic        rst_mmcm,
    output logic        locked,
    input  logic [6:0]  obs_addr,
    output logic [15:0] obs_data,
    output logic [7:0]  wr_count,
    output logic        protocol_err,
    output logic        wr_unsafe
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0]  LAT_LOAD  = 4'(DRDY_LATENCY - 1);
    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

    state_t      state, state_next;
    logic [15:0] regs [128];
    logic [3:0]  lat_cnt;
    logic [6:0]  cap_addr;
    logic [15:0] cap_din, cap_rdata;
    logic        cap_we, resp_we;
    logic [15:0] resp_rdata, lock_cnt;

    assign drdy     = (state == RESP);
    assign obs_data = regs[obs_addr];

    // With a latency of 1 the response follows the capture edge directly,
    // so the request is taken from the ports instead of the capture regs.
    assign resp_we    = (state == IDLE) ? dwe : cap_we;
    assign resp_rdata = (state == IDLE) ? regs[daddr] : cap_rdata;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = den ? ((DRDY_LATENCY == 1) ? RESP : WAIT) : IDLE;
            WAIT:    state_next = (lat_cnt == 4'd1) ? RESP : WAIT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            cap_addr     <= '0;
            cap_din      <= '0;
            cap_we       <= 1'b0;
            cap_rdata    <= '0;
            dout         <= '0;
            wr_count     <= '0;
            protocol_err <= 1'b0;
            wr_unsafe    <= 1'b0;
            for (int i = 0; i < 128; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && den) begin
                cap_addr  <= daddr;
                cap_din   <= din;
                cap_we    <= dwe;
                cap_rdata <= regs[daddr];
                lat_cnt   <= LAT_LOAD;
            end
            if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;
            if (state != IDLE && den) protocol_err <= 1'b1;
            if (state_next == RESP && !resp_we) dout <= resp_rdata;
            if (state == RESP && cap_we) begin
                regs[cap_addr] <= cap_din;
                wr_count       <= wr_count + 8'd1;
                if (!rst_mmcm) wr_unsafe <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (rst_mmcm) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (!locked) begin
            if (lock_cnt == LOCK_LAST) locked <= 1'b1;
            else lock_cnt <= lock_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_drp_responder.sv
// tb_drp_responder: directed self-checking bench for drp_responder
// (DRDY_LATENCY=3, LOCK_CYCLES=64).
module tb_drp_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  daddr = '0;
    logic [15:0] din = '0;
    logic        den = 1'b0;
    logic        dwe = 1'b0;
    logic [15:0] dout;
    logic        drdy;
    logic        rst_mmcm = 1'b0;
    logic        locked;
    logic [6:0]  obs_addr = '0;
    logic [15:0] obs_data;
    logic [7:0]  wr_count;
    logic        protocol_err;
    logic        wr_unsafe;

    int n_checks = 0;
    int n_fail   = 0;

    drp_responder #(.DRDY_LATENCY(3), .LOCK_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .daddr(daddr), .din(din), .den(den), .dwe(dwe),
        .dout(dout), .drdy(drdy), .rst_mmcm(rst_mmcm), .locked(locked),
        .obs_addr(obs_addr), .obs_data(obs_data), .wr_count(wr_count),
        .protocol_err(protocol_err), .wr_unsafe(wr_unsafe)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request; lat = cycles from the den cycle to the drdy cycle (0 on timeout).
    task automatic drp_op(input logic [6:0] a, input logic [15:0] d, input logic we,
                          output int lat, output logic [15:0] rd);
        daddr = a; din = d; dwe = we; den = 1'b1;
        lat = 0; rd = 16'hxxxx;
        for (int i = 1; i <= 20; i++) begin
            step();
            den = 1'b0; dwe = 1'b0;
            if (drdy) begin lat = i; rd = dout; break; end
        end
        step();
    endtask

    // Edges until locked is observed high (0 if it never rises within the bound).
    task automatic wait_lock(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (locked) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; rst_mmcm = 1'b0; obs_addr = 7'h08;
        step(); step();
        n_checks++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL reset_drdy got %0b want 0", drdy); end
        n_checks++; if (dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0000", dout); end
        n_checks++; if ({protocol_err, wr_unsafe, locked} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {protocol_err, wr_unsafe, locked}); end
        n_checks++; if (wr_count !== 8'd0) begin n_fail++; $display("FAIL reset_wr_count got %0d want 0", wr_count); end
        n_checks++; if (obs_data !== 16'h0) begin n_fail++; $display("FAIL reset_obs08 got %h want 0000", obs_data); end
        rst_n = 1'b1;
        wait_lock(n);
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL reset_lock_edges got %0d want 64", n); end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd;
        rst_mmcm = 1'b1;
        drp_op(7'h08, 16'h1145, 1'b1, lat, rd);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got %0d want 3", lat); end
        obs_addr = 7'h08; #1;
        n_checks++; if (obs_data !== 16'h1145) begin n_fail++; $display("FAIL wr_obs08 got %h want 1145", obs_data); end
        n_checks++; if (wr_count !== 8'd1) begin n_fail++; $display("FAIL wr_count1 got %0d want 1", wr_count); end
        n_checks++; if (wr_unsafe !== 1'b0) begin n_fail++; $display("FAIL wr_unsafe0 got %0b want 0", wr_unsafe); end
        n_checks++; if (dout !== 16'h0) begin n_fail++; $display("FAIL wr_dout_hold got %h want 0000", dout); end
        drp_op(7'h08, 16'h0000, 1'b0, lat, rd);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency got %0d want 3", lat); end
        n_checks++; if (rd !== 16'h1145) begin n_fail++; $display("FAIL rd_dout got %h want 1145", rd); end
        step(); step();
        n_checks++; if (dout !== 16'h1145) begin n_fail++; $display("FAIL rd_dout_idle got %h want 1145", dout); end
        n_checks++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL rd_drdy_single got %0b want 0", drdy); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        daddr = 7'h09; din = 16'hA5A5; dwe = 1'b1; den = 1'b1;
        step();
        dwe = 1'b0; den = 1'b1;
        step();
        den = 1'b0;
        if (drdy) pulses++;
        step();
        if (drdy) pulses++;
        den = 1'b1;
        step();
        den = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (drdy) pulses++;
            step();
        end
        obs_addr = 7'h09; #1;
        n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL busy_protocol_err got %0b want 1", protocol_err); end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL busy_drdy_count got %0d want 1", pulses); end
        n_checks++; if (obs_data !== 16'hA5A5) begin n_fail++; $display("FAIL busy_obs09 got %h want a5a5", obs_data); end
        n_checks++; if (wr_count !== 8'd2) begin n_fail++; $display("FAIL busy_wr_count got %0d want 2", wr_count); end
        n_checks++; if (dout !== 16'h1145) begin n_fail++; $display("FAIL busy_dout_hold got %h want 1145", dout); end
    endtask

    task automatic test_unsafe();
        int lat; logic [15:0] rd;
        rst_mmcm = 1'b0;
        drp_op(7'h4E, 16'hBEEF, 1'b1, lat, rd);
        obs_addr = 7'h4E; #1;
        n_checks++; if (wr_unsafe !== 1'b1) begin n_fail++; $display("FAIL unsafe_set got %0b want 1", wr_unsafe); end
        n_checks++; if (obs_data !== 16'hBEEF) begin n_fail++; $display("FAIL unsafe_obs4e got %h want beef", obs_data); end
        rst_mmcm = 1'b1;
        drp_op(7'h10, 16'h0F0F, 1'b1, lat, rd);
        n_checks++; if (wr_unsafe !== 1'b1) begin n_fail++; $display("FAIL unsafe_sticky got %0b want 1", wr_unsafe); end
        n_checks++; if (wr_count !== 8'd4) begin n_fail++; $display("FAIL unsafe_wr_count got %0d want 4", wr_count); end
    endtask

    task automatic test_mmcm_reset();
        int n;
        rst_mmcm = 1'b0;
        wait_lock(n);
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL mmcm_initial_lock got %0d want 64", n); end
        rst_mmcm = 1'b1;
        step();
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mmcm_fall got %0b want 0", locked); end
        for (int i = 0; i < 4; i++) step();
        rst_mmcm = 1'b0;
        wait_lock(n);
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL mmcm_relock got %0d want 64", n); end
        rst_mmcm = 1'b1;
        step();
        rst_mmcm = 1'b0;
        for (int i = 0; i < 30; i++) step();
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mmcm_count30 got %0b want 0", locked); end
        rst_mmcm = 1'b1;
        step();
        rst_mmcm = 1'b0;
        wait_lock(n);
        n_checks++; if (n !== 64) begin n_fail++; $display("FAIL mmcm_restart got %0d want 64", n); end
    endtask

    task automatic test_abort();
        int lat; int pulses = 0; logic [15:0] rd;
        rst_mmcm = 1'b1;
        daddr = 7'h20; din = 16'h1234; dwe = 1'b1; den = 1'b1;
        step();
        den = 1'b0; dwe = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1; if (drdy) pulses++;
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (drdy) pulses++;
            step();
        end
        obs_addr = 7'h20; #1;
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_drdy got %0d want 0", pulses); end
        n_checks++; if (obs_data !== 16'h0) begin n_fail++; $display("FAIL abort_obs20 got %h want 0000", obs_data); end
        n_checks++; if ({wr_count, protocol_err, wr_unsafe} !== 10'd0) begin n_fail++; $display("FAIL abort_clear got %h want 000", {wr_count, protocol_err, wr_unsafe}); end
        drp_op(7'h20, 16'h0, 1'b0, lat, rd);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL abort_next_latency got %0d want 3", lat); end
    endtask

    task automatic test_wrap();
        int lat; logic [15:0] rd;
        rst_mmcm = 1'b1;
        for (int i = 0; i < 255; i++) drp_op(7'(i), 16'(i), 1'b1, lat, rd);
        n_checks++; if (wr_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d want 255", wr_count); end
        drp_op(7'd127, 16'd255, 1'b1, lat, rd);
        n_checks++; if (wr_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0 got %0d want 0", wr_count); end
        obs_addr = 7'h05; #1;
        n_checks++; if (obs_data !== 16'h0085) begin n_fail++; $display("FAIL wrap_obs05 got %h want 0085", obs_data); end
        daddr = 7'h05; din = 16'hDEAD; dwe = 1'b1; den = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++; if (drdy !== 1'b0) begin n_fail++; $display("FAIL dwe_only_drdy got %0b want 0", drdy); end
        end
        dwe = 1'b0;
        step();
        n_checks++; if (obs_data !== 16'h0085) begin n_fail++; $display("FAIL dwe_only_obs05 got %h want 0085", obs_data); end
        n_checks++; if (wr_count !== 8'd0) begin n_fail++; $display("FAIL dwe_only_wr_count got %0d want 0", wr_count); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_unsafe();
        test_mmcm_reset();
        test_abort();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
